// File: rtl/count_monitor_pkg.sv
// Shared types and default sizes for the count_monitor sequence checker.
package count_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_ERRW  = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear plus increment in one cycle yields 1.
module sat_counter #(
    parameter int unsigned ERRW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [ERRW-1:0] count
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? ERRW'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + ERRW'(1);
        end
    end

endmodule

// File: rtl/count_monitor.sv
// Tracks an incrementing sample sequence, flags mismatches and counts them.
module count_monitor
    import count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned ERRW  = DEF_ERRW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             clr_err,
    output logic             locked,
    output logic             seq_err,
    output logic [ERRW-1:0]  err_count,
    output logic [WIDTH-1:0] last_even,
    output logic [WIDTH-1:0] dbl
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] expected;
    logic             accept;
    logic             mismatch;

    assign in_ready = (state != ERROR);
    assign accept   = in_valid && in_ready;
    assign mismatch = accept && (state == LOCKED) && (in_data != expected);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = LOCKED;
            LOCKED:  if (mismatch) state_next = ERROR;
            ERROR:   state_next = LOCKED;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            expected  <= '0;
            seq_err   <= 1'b0;
            locked    <= 1'b0;
            last_even <= '0;
            dbl       <= '0;
        end else begin
            state   <= state_next;
            seq_err <= mismatch;
            locked  <= (state_next != IDLE);
            // Lock, match-advance and resync all reduce to in_data+1.
            if (accept) begin
                expected <= in_data + WIDTH'(1);
                dbl      <= {in_data[WIDTH-2:0], 1'b0};
                if (!in_data[0]) begin
                    last_even <= in_data;
                end
            end
        end
    end

    sat_counter #(
        .ERRW(ERRW)
    ) u_err_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_err),
        .inc   (mismatch),
        .count (err_count)
    );

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench: a default-size instance and an 8-bit / 2-bit-counter instance.
module tb_count_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Default-parameter instance
    logic        rst_n_a, in_valid_a, clr_err_a;
    logic [31:0] in_data_a;
    logic        in_ready_a, locked_a, seq_err_a;
    logic [15:0] err_count_a;
    logic [31:0] last_even_a, dbl_a;

    // WIDTH=8, ERRW=2 instance
    logic        rst_n_b, in_valid_b, clr_err_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b, locked_b, seq_err_b;
    logic [1:0]  err_count_b;
    logic [7:0]  last_even_b, dbl_b;

    count_monitor dut_a (
        .clk       (clk),
        .rst_n     (rst_n_a),
        .in_valid  (in_valid_a),
        .in_data   (in_data_a),
        .in_ready  (in_ready_a),
        .clr_err   (clr_err_a),
        .locked    (locked_a),
        .seq_err   (seq_err_a),
        .err_count (err_count_a),
        .last_even (last_even_a),
        .dbl       (dbl_a)
    );

    count_monitor #(
        .WIDTH(8),
        .ERRW (2)
    ) dut_b (
        .clk       (clk),
        .rst_n     (rst_n_b),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .clr_err   (clr_err_b),
        .locked    (locked_b),
        .seq_err   (seq_err_b),
        .err_count (err_count_b),
        .last_even (last_even_b),
        .dbl       (dbl_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer_a(input logic [31:0] d);
        in_valid_a = 1'b1;
        in_data_a  = d;
        tick();
        in_valid_a = 1'b0;
    endtask

    task automatic offer_b(input logic [7:0] d);
        in_valid_b = 1'b1;
        in_data_b  = d;
        tick();
        in_valid_b = 1'b0;
    endtask

    initial begin
        rst_n_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0; clr_err_a = 1'b0;
        rst_n_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; clr_err_b = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_locked",    64'(locked_a),    0);
        check("rst_seq_err",   64'(seq_err_a),   0);
        check("rst_err_count", 64'(err_count_a), 0);
        check("rst_last_even", 64'(last_even_a), 0);
        check("rst_dbl",       64'(dbl_a),       0);
        rst_n_a = 1'b1;
        tick();
        check("rst_in_ready", 64'(in_ready_a), 1);
        check("rst_idle_locked", 64'(locked_a), 0);

        // Scenario 1: 0..9
        for (int i = 0; i < 10; i++) begin
            offer_a(32'(i));
            check("s1_locked",  64'(locked_a),  1);
            check("s1_seq_err", 64'(seq_err_a), 0);
        end
        check("s1_err_count", 64'(err_count_a), 0);
        check("s1_last_even", 64'(last_even_a), 8);
        check("s1_dbl",       64'(dbl_a),       18);

        // Scenario 2: 5, 6, 9, then 10
        rst_n_a = 1'b0;
        tick();
        rst_n_a = 1'b1;
        offer_a(32'd5);
        offer_a(32'd6);
        offer_a(32'd9);
        check("s2_seq_err_pulse", 64'(seq_err_a),   1);
        check("s2_in_ready_low",  64'(in_ready_a),  0);
        check("s2_err_count",     64'(err_count_a), 1);
        check("s2_locked_err",    64'(locked_a),    1);
        in_valid_a = 1'b1;
        in_data_a  = 32'd10;
        tick();
        check("s2_seq_err_end",   64'(seq_err_a),  0);
        check("s2_in_ready_back", 64'(in_ready_a), 1);
        check("s2_dbl_held",      64'(dbl_a),      18);
        tick();
        in_valid_a = 1'b0;
        check("s2_10_seq_err",   64'(seq_err_a),   0);
        check("s2_10_err_count", 64'(err_count_a), 1);
        check("s2_10_dbl",       64'(dbl_a),       20);

        // Scenario 5: gap of 7 cycles keeps lock; odd samples leave last_even
        for (int i = 0; i < 7; i++) tick();
        check("s5_gap_locked", 64'(locked_a), 1);
        offer_a(32'd11);
        check("s5_11_seq_err",   64'(seq_err_a),   0);
        check("s5_11_locked",    64'(locked_a),    1);
        check("s5_11_last_even", 64'(last_even_a), 10);
        offer_a(32'd13);
        check("s5_13_last_even", 64'(last_even_a), 10);
        check("s5_13_seq_err",   64'(seq_err_a),   1);
        check("s5_13_err_count", 64'(err_count_a), 2);

        // Scenario 6: reset during the seq_err pulse, with a sample offered
        rst_n_a    = 1'b0;
        in_valid_a = 1'b1;
        in_data_a  = 32'd14;
        tick();
        in_valid_a = 1'b0;
        check("s6_locked",    64'(locked_a),    0);
        check("s6_err_count", 64'(err_count_a), 0);
        check("s6_in_ready",  64'(in_ready_a),  1);
        check("s6_seq_err",   64'(seq_err_a),   0);
        check("s6_last_even", 64'(last_even_a), 0);
        check("s6_dbl",       64'(dbl_a),       0);
        rst_n_a = 1'b1;
        tick();
        check("s6_idle_locked", 64'(locked_a), 0);

        // Scenario 3 (WIDTH=8): wrap 254, 255, 0, 1
        rst_n_b = 1'b1;
        offer_b(8'd254);
        check("s3_254_locked", 64'(locked_b), 1);
        offer_b(8'd255);
        check("s3_255_seq_err", 64'(seq_err_b), 0);
        check("s3_255_dbl",     64'(dbl_b),     254);
        offer_b(8'd0);
        check("s3_0_seq_err", 64'(seq_err_b), 0);
        check("s3_0_dbl",     64'(dbl_b),     0);
        offer_b(8'd1);
        check("s3_1_seq_err",   64'(seq_err_b),   0);
        check("s3_1_dbl",       64'(dbl_b),       2);
        check("s3_err_count",   64'(err_count_b), 0);
        check("s3_last_even",   64'(last_even_b), 0);

        // Scenario 4 (ERRW=2): five mismatches saturate at 3
        for (int k = 1; k <= 5; k++) begin
            offer_b(8'd100);
            check("s4_seq_err",   64'(seq_err_b),   1);
            check("s4_err_count", 64'(err_count_b), (k > 3) ? 3 : k);
            tick();
        end
        clr_err_b = 1'b1;
        offer_b(8'd100);
        clr_err_b = 1'b0;
        check("s4_clr_and_inc", 64'(err_count_b), 1);
        clr_err_b = 1'b1;
        tick();
        clr_err_b = 1'b0;
        check("s4_clr_only", 64'(err_count_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
